imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_fetch_ctrl_if.sv | 43 ++++
 rtl/imem_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - fetch/decode/instruction-memory signal bundle for imem_fetch_ctrl
// master = fetch controller side, slave = memory/decode/control side.
interface imem_fetch_ctrl_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_data;
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst_out;
   logic [ADDR_W+1:0] inst_pc;
   logic              redirect_valid;
   logic [ADDR_W+1:0] redirect_pc;
   logic              resume;
   logic              halted;

   modport master (
      output imem_addr,
      input  imem_data,
      output inst_valid,
      input  inst_ready,
      output inst_out,
      output inst_pc,
      input  redirect_valid,
      input  redirect_pc,
      input  resume,
      output halted
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  inst_valid,
      output inst_ready,
      input  inst_out,
      input  inst_pc,
      output redirect_valid,
      output redirect_pc,
      output resume,
      input  halted
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer with prefetch FIFO, redirect flush and EBREAK halt
// Optional IMEM_FETCH_PERF_EN adds saturating fetch/stall counters.
module imem_fetch_ctrl #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int RESET_PC   = 0
) (
   input  logic                clk,
   input  logic                rst,
   imem_fetch_ctrl_if.master   fetch_if
`ifdef IMEM_FETCH_PERF_EN
   ,
   output logic [15:0]         perf_fetch_cnt,
   output logic [15:0]         perf_stall_cnt
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [DATA_W-1:0] EBREAK_C = DATA_W'(32'h00100073);

   typedef enum logic {ST_RUN, ST_HALT} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];

   logic full, pop, push, is_ebreak, redirect;
   logic unused_redirect_lsb;

   assign redirect            = fetch_if.redirect_valid;
   assign unused_redirect_lsb = ^fetch_if.redirect_pc[1:0];

   always_comb begin
      full      = (cnt_q == DEPTH_C);
      pop       = (cnt_q != '0) && fetch_if.inst_ready;
      // A pop at the same edge frees the slot, so a full FIFO still streams one per cycle.
      push      = (state_q == ST_RUN) && !redirect && (!full || pop);
      is_ebreak = (fetch_if.imem_data == EBREAK_C);

      state_d  = state_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;

      if (redirect) begin
         pc_d     = fetch_if.redirect_pc[ADDR_W+1:2];
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            pc_d     = pc_q + ADDR_W'(1);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end

      case (state_q)
         ST_RUN: begin
            if (push && is_ebreak) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            if (fetch_if.resume) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= ADDR_W'(RESET_PC);
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else if (push) begin
         data_q[wr_ptr_q] <= fetch_if.imem_data;
         addr_q[wr_ptr_q] <= pc_q;
      end
   end

   assign fetch_if.imem_addr  = pc_q;
   assign fetch_if.inst_valid = (cnt_q != '0);
   assign fetch_if.inst_out   = data_q[rd_ptr_q];
   assign fetch_if.inst_pc    = {addr_q[rd_ptr_q], 2'b00};
   assign fetch_if.halted     = (state_q == ST_HALT);

`ifdef IMEM_FETCH_PERF_EN
   logic stall;
   assign stall = (state_q == ST_RUN) && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (push && (perf_fetch_cnt != 16'hFFFF)) begin
            perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
         end
         if (stall && (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
// Honours IMEM_FETCH_PERF_EN when defined.
module tb_imem_fetch_ctrl;
   logic clk;
   logic rst;
   logic [31:0] mem [64];
   logic [39:0] sb [$];
   int checks;
   int failures;

   imem_fetch_ctrl_if #(.ADDR_W(6), .DATA_W(32)) fif ();
   assign fif.imem_data = mem[fif.imem_addr];

`ifdef IMEM_FETCH_PERF_EN
   logic [15:0] perf_fetch_cnt;
   logic [15:0] perf_stall_cnt;
`endif

   imem_fetch_ctrl #(.ADDR_W(6), .DATA_W(32), .FIFO_DEPTH(2), .RESET_PC(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .fetch_if (fif)
`ifdef IMEM_FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every accepted instruction must match the next expected entry.
   always @(negedge clk) begin
      if (rst === 1'b0 && fif.inst_valid === 1'b1 && fif.inst_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_extra: got inst=%h pc=%h, expected none", fif.inst_out, fif.inst_pc);
         end else begin
            logic [39:0] exp;
            exp = sb.pop_front();
            if ({fif.inst_out, fif.inst_pc} !== exp)
               begin failures++; $display("FAIL sb_order: got inst=%h pc=%h want inst=%h pc=%h", fif.inst_out, fif.inst_pc, exp[39:8], exp[7:0]); end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic hold_off;
      @(negedge clk);
      #1;
      fif.inst_ready = 1'b0;
   endtask

   task automatic sb_push(input int w);
      logic [7:0] bpc;
      bpc = 8'(w * 4);
      sb.push_back({mem[w], bpc});
   endtask

   task automatic do_reset(input logic rdy);
      rst = 1'b1;
      fif.inst_ready = rdy;
      fif.redirect_valid = 1'b0;
      fif.redirect_pc = '0;
      fif.resume = 1'b0;
      sb.delete();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset(1'b1);
      checks++; if (fif.inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", fif.inst_valid); end
      checks++; if (fif.inst_out !== 32'h0) begin failures++; $display("FAIL rst_inst_out: got %h want 0", fif.inst_out); end
      checks++; if (fif.inst_pc !== 8'h0) begin failures++; $display("FAIL rst_inst_pc: got %h want 0", fif.inst_pc); end
      checks++; if (fif.halted !== 1'b0) begin failures++; $display("FAIL rst_halted: got %b want 0", fif.halted); end
      checks++; if (fif.imem_addr !== 6'd0) begin failures++; $display("FAIL rst_addr: got %0d want 0", fif.imem_addr); end
`ifdef IMEM_FETCH_PERF_EN
      checks++; if (perf_fetch_cnt !== 16'd0) begin failures++; $display("FAIL rst_perf_fetch: got %0d want 0", perf_fetch_cnt); end
`endif
   endtask

   task automatic test_stream;
      do_reset(1'b1);
      for (int w = 0; w < 6; w++) sb_push(w);
      tick();
      checks++; if (fif.inst_out !== 32'h00000083 || fif.inst_pc !== 8'h00 || fif.inst_valid !== 1'b1)
         begin failures++; $display("FAIL stream_e1: got v=%b %h pc=%h want 1 00000083 pc=00", fif.inst_valid, fif.inst_out, fif.inst_pc); end
      tick();
      checks++; if (fif.inst_out !== 32'h00100103 || fif.inst_pc !== 8'h04)
         begin failures++; $display("FAIL stream_e2: got %h pc=%h want 00100103 pc=04", fif.inst_out, fif.inst_pc); end
      for (int i = 0; i < 4; i++) tick();
      hold_off();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL stream_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_backpressure;
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i >= 1) begin
            checks++; if (fif.imem_addr !== 6'd2) begin failures++; $display("FAIL bp_addr_hold: got %0d want 2", fif.imem_addr); end
         end
      end
      checks++; if (fif.inst_out !== 32'h00000083 || fif.inst_valid !== 1'b1)
         begin failures++; $display("FAIL bp_head: got v=%b %h want 1 00000083", fif.inst_valid, fif.inst_out); end
`ifdef IMEM_FETCH_PERF_EN
      checks++; if (perf_fetch_cnt !== 16'd2 || perf_stall_cnt !== 16'd3)
         begin failures++; $display("FAIL bp_perf: got fetch=%0d stall=%0d want 2 3", perf_fetch_cnt, perf_stall_cnt); end
`endif
      for (int w = 0; w < 3; w++) sb_push(w);
      fif.inst_ready = 1'b1;
      tick();
      tick();
      hold_off();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_redirect;
      do_reset(1'b0);
      tick();
      tick();
      fif.redirect_valid = 1'b1;
      fif.redirect_pc = 8'h40;
      tick();
      fif.redirect_valid = 1'b0;
      checks++; if (fif.inst_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: got v=%b want 0", fif.inst_valid); end
      checks++; if (fif.imem_addr !== 6'd16) begin failures++; $display("FAIL redir_addr: got %0d want 16", fif.imem_addr); end
      tick();
      checks++; if (fif.inst_out !== 32'h40208733 || fif.inst_pc !== 8'h40 || fif.inst_valid !== 1'b1)
         begin failures++; $display("FAIL redir_target: got v=%b %h pc=%h want 1 40208733 pc=40", fif.inst_valid, fif.inst_out, fif.inst_pc); end
      sb_push(16);
      sb_push(17);
      fif.inst_ready = 1'b1;
      tick();
      hold_off();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL redir_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_redirect_pop;
      do_reset(1'b1);
      sb_push(0);
      sb_push(1);
      sb_push(40);
      sb_push(41);
      tick();
      tick();
      fif.redirect_valid = 1'b1;
      fif.redirect_pc = 8'hA3;
      tick();
      fif.redirect_valid = 1'b0;
      checks++; if (fif.inst_valid !== 1'b0) begin failures++; $display("FAIL rpop_flush: got v=%b want 0", fif.inst_valid); end
      tick();
      tick();
      hold_off();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL rpop_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_ebreak;
      do_reset(1'b1);
      for (int w = 0; w < 9; w++) sb_push(w);
      for (int i = 0; i < 9; i++) tick();
      checks++; if (fif.halted !== 1'b1) begin failures++; $display("FAIL ebrk_halted: got %b want 1", fif.halted); end
      checks++; if (fif.imem_addr !== 6'd9) begin failures++; $display("FAIL ebrk_addr: got %0d want 9", fif.imem_addr); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (fif.inst_valid !== 1'b0 || fif.imem_addr !== 6'd9 || fif.halted !== 1'b1)
            begin failures++; $display("FAIL ebrk_hold: got v=%b addr=%0d h=%b want 0 9 1", fif.inst_valid, fif.imem_addr, fif.halted); end
      end
      fif.resume = 1'b1;
      tick();
      fif.resume = 1'b0;
      checks++; if (fif.halted !== 1'b0) begin failures++; $display("FAIL ebrk_resume: got h=%b want 0", fif.halted); end
      sb_push(9);
      sb_push(10);
      tick();
      checks++; if (fif.inst_out !== 32'h0000000f || fif.inst_pc !== 8'h24)
         begin failures++; $display("FAIL ebrk_next: got %h pc=%h want 0000000f pc=24", fif.inst_out, fif.inst_pc); end
      tick();
      hold_off();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL ebrk_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_halt_redirect;
      do_reset(1'b0);
      fif.redirect_valid = 1'b1;
      fif.redirect_pc = 8'h20;
      tick();
      fif.redirect_valid = 1'b0;
      tick();
      checks++; if (fif.halted !== 1'b1 || fif.imem_addr !== 6'd9)
         begin failures++; $display("FAIL hr_halt: got h=%b addr=%0d want 1 9", fif.halted, fif.imem_addr); end
      fif.redirect_valid = 1'b1;
      fif.redirect_pc = 8'h40;
      tick();
      fif.redirect_valid = 1'b0;
      tick();
      checks++; if (fif.halted !== 1'b1 || fif.imem_addr !== 6'd16 || fif.inst_valid !== 1'b0)
         begin failures++; $display("FAIL hr_redir: got h=%b addr=%0d v=%b want 1 16 0", fif.halted, fif.imem_addr, fif.inst_valid); end
      fif.redirect_valid = 1'b1;
      fif.redirect_pc = 8'h24;
      fif.resume = 1'b1;
      tick();
      fif.redirect_valid = 1'b0;
      fif.resume = 1'b0;
      checks++; if (fif.halted !== 1'b0 || fif.imem_addr !== 6'd9)
         begin failures++; $display("FAIL hr_both: got h=%b addr=%0d want 0 9", fif.halted, fif.imem_addr); end
      tick();
      checks++; if (fif.inst_valid !== 1'b1 || fif.inst_out !== 32'h0000000f || fif.inst_pc !== 8'h24)
         begin failures++; $display("FAIL hr_fetch: got v=%b %h pc=%h want 1 0000000f pc=24", fif.inst_valid, fif.inst_out, fif.inst_pc); end
   endtask

   task automatic test_wrap;
      do_reset(1'b0);
      fif.redirect_valid = 1'b1;
      fif.redirect_pc = 8'hFC;
      tick();
      fif.redirect_valid = 1'b0;
      tick();
      checks++; if (fif.inst_pc !== 8'hFC || fif.inst_out !== mem[63] || fif.imem_addr !== 6'd0)
         begin failures++; $display("FAIL wrap_63: got %h pc=%h addr=%0d want %h pc=fc addr=0", fif.inst_out, fif.inst_pc, fif.imem_addr, mem[63]); end
      sb_push(63);
      sb_push(0);
      fif.inst_ready = 1'b1;
      tick();
      checks++; if (fif.inst_out !== 32'h00000083 || fif.inst_pc !== 8'h00)
         begin failures++; $display("FAIL wrap_0: got %h pc=%h want 00000083 pc=00", fif.inst_out, fif.inst_pc); end
      hold_off();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL wrap_drain: got %0d left want 0", sb.size()); end
   endtask

   task automatic test_midreset;
      do_reset(1'b0);
      fif.redirect_valid = 1'b1;
      fif.redirect_pc = 8'h20;
      tick();
      fif.redirect_valid = 1'b0;
      tick();
      checks++; if (fif.halted !== 1'b1 || fif.inst_valid !== 1'b1)
         begin failures++; $display("FAIL mid_pre: got h=%b v=%b want 1 1", fif.halted, fif.inst_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (fif.inst_valid !== 1'b0 || fif.halted !== 1'b0 || fif.imem_addr !== 6'd0)
         begin failures++; $display("FAIL mid_async: got v=%b h=%b addr=%0d want 0 0 0", fif.inst_valid, fif.halted, fif.imem_addr); end
      tick();
      rst = 1'b0;
      fif.inst_ready = 1'b1;
      sb_push(0);
      sb_push(1);
      tick();
      tick();
      hold_off();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_drain: got %0d left want 0", sb.size()); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      fif.inst_ready = 1'b0;
      fif.redirect_valid = 1'b0;
      fif.redirect_pc = '0;
      fif.resume = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0000000 | 32'(i);
      mem[0]  = 32'h00000083;
      mem[1]  = 32'h00100103;
      mem[2]  = 32'h002081b3;
      mem[8]  = 32'h00100073;
      mem[9]  = 32'h0000000f;
      mem[16] = 32'h40208733;

      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_pop();
      test_ebreak();
      test_halt_redirect();
      test_wrap();
      test_midreset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
